// File: rtl/zigzag_encoder_pkg.sv
// Shared types, widths and the JPEG zigzag scan tables for the zigzag encoder.
package zigzag_encoder_pkg;

    localparam int COEF_WIDTH = 12;
    localparam int RUN_WIDTH  = 6;
    localparam int BLOCK_DIM  = 8;

    typedef logic signed [COEF_WIDTH-1:0] coef_t;

    typedef struct packed {
        logic [RUN_WIDTH-1:0] run;
        coef_t                value;
        logic                 eob;
        logic                 last;
    } token_t;

    typedef enum logic {
        LOAD = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Zigzag index k -> (row, col) of the 8x8 block.
    localparam logic [2:0] ZIGZAG_ROW [64] = '{
        3'd0, 3'd0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1,
        3'd2, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0,
        3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd5, 3'd4,
        3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3,
        3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4,
        3'd3, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6,
        3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd4, 3'd5,
        3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd6, 3'd7, 3'd7
    };

    localparam logic [2:0] ZIGZAG_COL [64] = '{
        3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd2,
        3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
        3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2,
        3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd5, 3'd4,
        3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
        3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3,
        3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6,
        3'd5, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd7
    };

endpackage

// File: rtl/zigzag_encoder_if.sv
// Column input stream and (run, value) token output stream of the zigzag encoder.
interface zigzag_encoder_if;
    import zigzag_encoder_pkg::*;

    logic [BLOCK_DIM*COEF_WIDTH-1:0] column_in;
    logic                            valid_in;
    logic                            ready_out;
    coef_t                           value_out;
    logic [RUN_WIDTH-1:0]            run_out;
    logic                            eob_out;
    logic                            last_out;
    logic                            valid_out;
    logic                            ready_in;

    modport slave (
        input  column_in, valid_in, ready_in,
        output ready_out, value_out, run_out, eob_out, last_out, valid_out
    );

    modport master (
        output column_in, valid_in, ready_in,
        input  ready_out, value_out, run_out, eob_out, last_out, valid_out
    );

endinterface

// File: rtl/zigzag_encoder_lut.sv
// Combinational zigzag index to block position lookup.
module zigzag_lut
    import zigzag_encoder_pkg::*;
(
    input  logic [5:0] k,
    output logic [2:0] row,
    output logic [2:0] col
);

    assign row = ZIGZAG_ROW[k];
    assign col = ZIGZAG_COL[k];

endmodule

// File: rtl/zigzag_encoder.sv
// Buffers an 8x8 coefficient block column by column, then scans it in zigzag order emitting (run, value) tokens.
// Optional macro ZRL_SPLIT_EN: split runs longer than 15 into ZRL tokens before the coefficient.
module zigzag_encoder
    import zigzag_encoder_pkg::*;
(
    input logic             clk_in,
    input logic             rst_in,
    zigzag_encoder_if.slave bus
);

    state_t               state, state_nxt;
    logic [2:0]           col_cnt, col_cnt_nxt;
    logic [5:0]           k, k_nxt;
    logic [RUN_WIDTH-1:0] run, run_nxt;

    coef_t                buffer [BLOCK_DIM][BLOCK_DIM];
    logic [2:0]           zz_row, zz_col;
    coef_t                coef;

    token_t               tok_nxt, tok_p1;
    logic                 vld_p1;
    logic                 emit;
    logic                 accept;
    logic                 advance;

    zigzag_lut u_lut (
        .k   (k),
        .row (zz_row),
        .col (zz_col)
    );

    assign coef    = buffer[zz_row][zz_col];
    assign accept  = bus.valid_in && (state == LOAD);
    assign advance = (state == SCAN) && (!vld_p1 || bus.ready_in);

    always_ff @(posedge clk_in) begin
        if (accept) begin
            for (int r = 0; r < BLOCK_DIM; r++) begin
                buffer[r][col_cnt] <= bus.column_in[r*COEF_WIDTH +: COEF_WIDTH];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        col_cnt_nxt = col_cnt;
        k_nxt       = k;
        run_nxt     = run;
        emit        = 1'b0;
        tok_nxt     = '0;
        unique case (state)
            LOAD: begin
                if (accept) begin
                    col_cnt_nxt = col_cnt + 3'd1;
                    if (col_cnt == 3'd7) begin
                        state_nxt = SCAN;
                    end
                end
            end
            SCAN: begin
                if (advance) begin
                    if (k == 6'd0) begin
                        emit          = 1'b1;
                        tok_nxt.value = coef;
                        k_nxt         = 6'd1;
                    end else if (coef != '0) begin
`ifdef ZRL_SPLIT_EN
                        // Long run: emit a ZRL and hold k until the residual run fits.
                        if (run > RUN_WIDTH'(15)) begin
                            emit        = 1'b1;
                            tok_nxt.run = RUN_WIDTH'(15);
                            run_nxt     = run - RUN_WIDTH'(16);
                        end else
`endif
                        begin
                            emit          = 1'b1;
                            tok_nxt.run   = run;
                            tok_nxt.value = coef;
                            tok_nxt.last  = (k == 6'd63);
                            run_nxt       = '0;
                            k_nxt         = k + 6'd1;
                        end
                    end else if (k == 6'd63) begin
                        emit         = 1'b1;
                        tok_nxt.eob  = 1'b1;
                        tok_nxt.last = 1'b1;
                    end else begin
                        run_nxt = run + RUN_WIDTH'(1);
                        k_nxt   = k + 6'd1;
                    end
                    if (emit && tok_nxt.last) begin
                        state_nxt = LOAD;
                        k_nxt     = '0;
                        run_nxt   = '0;
                    end
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state   <= LOAD;
            col_cnt <= '0;
            k       <= '0;
            run     <= '0;
        end else begin
            state   <= state_nxt;
            col_cnt <= col_cnt_nxt;
            k       <= k_nxt;
            run     <= run_nxt;
        end
    end

    // Output token register: holds until the downstream takes it.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tok_p1 <= '0;
            vld_p1 <= 1'b0;
        end else if (advance && emit) begin
            tok_p1 <= tok_nxt;
            vld_p1 <= 1'b1;
        end else if (vld_p1 && bus.ready_in) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.ready_out = (state == LOAD);
    assign bus.value_out = tok_p1.value;
    assign bus.run_out   = tok_p1.run;
    assign bus.eob_out   = tok_p1.eob;
    assign bus.last_out  = tok_p1.last;
    assign bus.valid_out = vld_p1;

endmodule

// File: tb/tb_zigzag_encoder.sv
// Scoreboard bench for zigzag_encoder: directed blocks, stalls and a mid-scan reset; honours ZRL_SPLIT_EN.
module tb_zigzag_encoder;

    typedef struct packed {
        logic [5:0]         run;
        logic signed [11:0] value;
        logic               eob;
        logic               last;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst_in;
    always #5 clk_in = ~clk_in;

    zigzag_encoder_if ifc ();

    zigzag_encoder dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (ifc)
    );

    exp_t               q[$];
    int                 checks = 0;
    int                 errors = 0;
    int                 zr [64];
    int                 zc [64];
    logic signed [11:0] blk [8][8];
    exp_t               held_tok;
    bit                 held_v = 1'b0;
    exp_t               observed;

    assign observed = {ifc.run_out, ifc.value_out, ifc.eob_out, ifc.last_out};

    function automatic exp_t mk(int run, int value, bit eob, bit last);
        exp_t t;
        t.run   = 6'(run);
        t.value = 12'(value);
        t.eob   = eob;
        t.last  = last;
        return t;
    endfunction

    // Zigzag order from anti-diagonal traversal, independent of the RTL tables.
    task automatic build_zigzag();
        int n = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zr[n] = r; zc[n] = s - r; n++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zr[n] = r; zc[n] = s - r; n++; end
            end
        end
    endtask

    task automatic clear_blk();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                blk[r][c] = '0;
    endtask

    task automatic ramp_blk();
        for (int i = 0; i < 64; i++) blk[zr[i]][zc[i]] = 12'(i + 1);
    endtask

    task automatic expect_block();
        int run = 0;
        for (int i = 0; i < 64; i++) begin
            int v = int'(blk[zr[i]][zc[i]]);
            if (i == 0) begin
                q.push_back(mk(0, v, 1'b0, 1'b0));
            end else if (v != 0) begin
`ifdef ZRL_SPLIT_EN
                while (run > 15) begin
                    q.push_back(mk(15, 0, 1'b0, 1'b0));
                    run -= 16;
                end
`endif
                q.push_back(mk(run, v, 1'b0, i == 63));
                run = 0;
            end else if (i == 63) begin
                q.push_back(mk(0, 0, 1'b1, 1'b1));
            end else begin
                run++;
            end
        end
    endtask

    task automatic send_block();
        bit acc;
        int n;
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 8; r++) ifc.column_in[r*12 +: 12] = blk[r][c];
            ifc.valid_in = 1'b1;
            n = 0;
            do begin
                @(negedge clk_in);
                acc = ifc.ready_out;
                @(posedge clk_in);
                #1;
                n++;
            end while (!acc && n < 500);
            checks++;
            assert (acc === 1'b1) else begin
                errors++;
                $error("FAIL col_accept col=%0d observed=%0b expected=1", c, acc);
            end
        end
        ifc.valid_in = 1'b0;
        checks++;
        assert (ifc.ready_out === 1'b0) else begin
            errors++;
            $error("FAIL ready_low_in_scan observed=%0b expected=0", ifc.ready_out);
        end
        @(posedge clk_in);
        #1;
        checks++;
        assert (ifc.valid_out === 1'b1) else begin
            errors++;
            $error("FAIL first_token_latency observed=%0b expected=1", ifc.valid_out);
        end
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(posedge clk_in);
            #1;
            ifc.ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        ifc.ready_in = 1'b1;
        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL drain_timeout observed_left=%0d expected=0", q.size());
        end
        repeat (2) @(posedge clk_in);
        #1;
        checks++;
        assert (ifc.ready_out === 1'b1 && ifc.valid_out === 1'b0) else begin
            errors++;
            $error("FAIL idle_after_block observed ready=%0b valid=%0b expected ready=1 valid=0",
                   ifc.ready_out, ifc.valid_out);
        end
    endtask

    // Token monitor: stall stability and in-order scoreboard comparison.
    always @(negedge clk_in) begin
        if (rst_in) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                checks++;
                assert (ifc.valid_out === 1'b1 && observed === held_tok) else begin
                    errors++;
                    $error("FAIL stall_hold observed=%h valid=%0b expected=%h valid=1",
                           observed, ifc.valid_out, held_tok);
                end
            end
            held_v = 1'b0;
            if (ifc.valid_out === 1'b1) begin
                if (ifc.ready_in === 1'b1) begin
                    checks++;
                    assert (q.size() > 0) else begin
                        errors++;
                        $error("FAIL extra_token observed run=%0d val=%0d expected none",
                               ifc.run_out, ifc.value_out);
                    end
                    if (q.size() > 0) begin
                        exp_t e;
                        e = q.pop_front();
                        checks++;
                        assert (observed === e) else begin
                            errors++;
                            $error("FAIL token observed run=%0d val=%0d eob=%0b last=%0b expected run=%0d val=%0d eob=%0b last=%0b",
                                   observed.run, observed.value, observed.eob, observed.last,
                                   e.run, e.value, e.eob, e.last);
                        end
                    end
                end else begin
                    held_v   = 1'b1;
                    held_tok = observed;
                end
            end
        end
    end

    initial begin
        build_zigzag();
        ifc.column_in = '0;
        ifc.valid_in  = 1'b0;
        ifc.ready_in  = 1'b1;
        rst_in        = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        checks++;
        assert (ifc.ready_out === 1'b1 && ifc.valid_out === 1'b0 && observed === '0) else begin
            errors++;
            $error("FAIL reset_state observed ready=%0b valid=%0b tok=%h expected ready=1 valid=0 tok=0",
                   ifc.ready_out, ifc.valid_out, observed);
        end
        rst_in = 1'b0;

        clear_blk();
        expect_block();
        send_block();
        drain(1'b0);

        clear_blk();
        blk[0][0] = -12'sd5;
        expect_block();
        send_block();
        drain(1'b0);

        clear_blk();
        ramp_blk();
        expect_block();
        send_block();
        drain(1'b0);

        clear_blk();
        blk[0][0] = 12'sd3;
        blk[0][1] = 12'sd7;
        blk[5][0] = -12'sd2;
        expect_block();
        send_block();
        drain(1'b0);

        clear_blk();
        ramp_blk();
        expect_block();
        send_block();
        drain(1'b1);

        clear_blk();
        blk[0][0] = 12'sd3;
        blk[0][1] = 12'sd7;
        blk[5][0] = -12'sd2;
        expect_block();
        send_block();
        drain(1'b1);

        clear_blk();
        ramp_blk();
        expect_block();
        send_block();
        repeat (10) @(posedge clk_in);
        #3;
        rst_in = 1'b1;
        #1;
        checks++;
        assert (ifc.ready_out === 1'b1 && ifc.valid_out === 1'b0 && observed === '0) else begin
            errors++;
            $error("FAIL async_reset observed ready=%0b valid=%0b tok=%h expected ready=1 valid=0 tok=0",
                   ifc.ready_out, ifc.valid_out, observed);
        end
        q.delete();
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        clear_blk();
        ramp_blk();
        expect_block();
        send_block();
        drain(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
